// File: rtl/mem_bus_pkg.sv
// Shared load/store bus definitions: funct3 access-size codes and the responder FSM encoding.
package mem_bus_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational lane steering: byte enables and merge for stores, extraction and extension for loads,
// plus the illegal-option / misalignment flag.
module mem_byte_lane
   import mem_bus_pkg::*;
(
   input  logic        i_is_write,
   input  logic [2:0]  i_option,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_word,
   input  logic [31:0] i_write_data,
   output logic [3:0]  o_be,
   output logic [31:0] o_merged,
   output logic [31:0] o_rdata,
   output logic        o_bad
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_wlane;

   assign w_byte = i_word[{i_addr, 3'b000} +: 8];
   assign w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];

   always_comb begin
      o_be    = 4'b0000;
      o_bad   = 1'b0;
      o_rdata = 32'h0;
      w_wlane = i_write_data;
      case (i_option)
         F3_B: begin
            o_be    = 4'b0001 << i_addr;
            w_wlane = {4{i_write_data[7:0]}};
            o_rdata = {{24{w_byte[7]}}, w_byte};
         end
         F3_H: begin
            o_bad   = i_addr[0];
            o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
            w_wlane = {2{i_write_data[15:0]}};
            o_rdata = {{16{w_half[15]}}, w_half};
         end
         F3_W: begin
            o_bad   = (i_addr != 2'b00);
            o_be    = 4'b1111;
            o_rdata = i_word;
         end
         F3_BU: begin
            o_bad   = i_is_write;
            o_rdata = {24'h0, w_byte};
         end
         F3_HU: begin
            o_bad   = i_is_write | i_addr[0];
            o_rdata = {16'h0, w_half};
         end
         default: o_bad = 1'b1;
      endcase
      // A flagged access must never touch storage.
      if (o_bad) o_be = 4'b0000;
   end

   always_comb begin
      o_merged = i_word;
      for (int i = 0; i < 4; i++)
         if (o_be[i]) o_merged[8*i +: 8] = w_wlane[8*i +: 8];
   end

endmodule

// File: rtl/mem_responder.sv
// Word-organised RAM responder: one request at a time, fixed LATENCY, single-cycle mem_response.
module mem_responder
   import mem_bus_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  option,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        mem_response,
   output logic        mem_error
);

   state_t                r_state, w_state_n;
   logic [3:0]            r_cnt, w_cnt_n;
   logic                  r_rd, r_wr;
   logic [2:0]            r_opt;
   logic [ADDR_WIDTH+1:0] r_addr;
   logic [31:0]           r_wd;
   logic [31:0]           r_read_data;
   logic                  r_error;
   logic [31:0]           r_mem [0:(2**ADDR_WIDTH)-1];

   logic                  w_idle, w_capture, w_enter_resp;
   logic                  w_rd, w_wr, w_err, w_bad, w_we;
   logic [2:0]            w_opt;
   logic [ADDR_WIDTH+1:0] w_addr;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic [31:0]           w_wd, w_word, w_merged, w_rdata;
   logic [3:0]            w_be;
   logic                  w_unused_addr;

   assign w_unused_addr = ^address[31:ADDR_WIDTH+2];

   assign w_idle    = (r_state == IDLE);
   assign w_capture = w_idle & (mem_read | mem_write);

   // With LATENCY=1 the capture edge is also the RESP entry edge, so the
   // request is evaluated from the live inputs while idle.
   assign w_rd   = w_idle ? mem_read   : r_rd;
   assign w_wr   = w_idle ? mem_write  : r_wr;
   assign w_opt  = w_idle ? option     : r_opt;
   assign w_addr = w_idle ? address[ADDR_WIDTH+1:0] : r_addr;
   assign w_wd   = w_idle ? write_data : r_wd;
   assign w_idx  = w_addr[ADDR_WIDTH+1:2];
   assign w_word = r_mem[w_idx];

   mem_byte_lane u_lane (
      .i_is_write   (w_wr),
      .i_option     (w_opt),
      .i_addr       (w_addr[1:0]),
      .i_word       (w_word),
      .i_write_data (w_wd),
      .o_be         (w_be),
      .o_merged     (w_merged),
      .o_rdata      (w_rdata),
      .o_bad        (w_bad)
   );

   assign w_err = (w_rd & w_wr) | w_bad;
   assign w_we  = w_enter_resp & w_wr & ~w_rd & (|w_be) & resetn;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
      end
   end

   always_comb begin
      w_state_n    = r_state;
      w_cnt_n      = r_cnt;
      w_enter_resp = 1'b0;
      case (r_state)
         IDLE: if (mem_read | mem_write) begin
            if (LATENCY == 1) begin
               w_state_n    = RESP;
               w_enter_resp = 1'b1;
            end else begin
               w_state_n = BUSY;
               w_cnt_n   = 4'(LATENCY - 1);
            end
         end
         BUSY: if (r_cnt == 4'd1) begin
            w_state_n    = RESP;
            w_enter_resp = 1'b1;
            w_cnt_n      = 4'd0;
         end else begin
            w_cnt_n = r_cnt - 4'd1;
         end
         RESP:    w_state_n = IDLE;
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rd   <= 1'b0;
         r_wr   <= 1'b0;
         r_opt  <= 3'd0;
         r_addr <= '0;
         r_wd   <= 32'h0;
      end else if (w_capture) begin
         r_rd   <= mem_read;
         r_wr   <= mem_write;
         r_opt  <= option;
         r_addr <= address[ADDR_WIDTH+1:0];
         r_wd   <= write_data;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_read_data <= 32'h0;
         r_error     <= 1'b0;
      end else if (w_enter_resp) begin
         r_error     <= w_err;
         r_read_data <= (w_err | ~w_rd) ? 32'h0 : w_rdata;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_idx] <= w_merged;
   end

   assign read_data    = r_read_data;
   assign mem_error    = r_error;
   assign mem_response = (r_state == RESP);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 1, 4, 3) driven by a vector table and hand sequences.
module tb_mem_responder;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  opt;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] ed;
      logic        ee;
   } vec_t;

   typedef struct {
      int          k;
      logic [31:0] data;
      logic        err;
      logic        cd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn [3];
   logic        rd   [3];
   logic        wr   [3];
   logic [2:0]  opt  [3];
   logic [31:0] addr [3];
   logic [31:0] wd   [3];
   logic [31:0] rdat [3];
   logic        resp [3];
   logic        err  [3];
   int          lat  [3] = '{1, 4, 3};

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t tv [28];

   always #5 clk = ~clk;

   mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_l1 (
      .clk(clk), .resetn(rstn[0]), .mem_read(rd[0]), .mem_write(wr[0]), .option(opt[0]),
      .address(addr[0]), .write_data(wd[0]), .read_data(rdat[0]), .mem_response(resp[0]),
      .mem_error(err[0]));
   mem_responder #(.ADDR_WIDTH(10), .LATENCY(4)) u_l4 (
      .clk(clk), .resetn(rstn[1]), .mem_read(rd[1]), .mem_write(wr[1]), .option(opt[1]),
      .address(addr[1]), .write_data(wd[1]), .read_data(rdat[1]), .mem_response(resp[1]),
      .mem_error(err[1]));
   mem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) u_l3 (
      .clk(clk), .resetn(rstn[2]), .mem_read(rd[2]), .mem_write(wr[2]), .option(opt[2]),
      .address(addr[2]), .write_data(wd[2]), .read_data(rdat[2]), .mem_response(resp[2]),
      .mem_error(err[2]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic idle(input int k);
      rd[k] = 1'b0; wr[k] = 1'b0; opt[k] = 3'd0; addr[k] = 32'h0; wd[k] = 32'h0;
   endtask

   task automatic drive(input int k, input vec_t v);
      rd[k] = v.rd; wr[k] = v.wr; opt[k] = v.opt; addr[k] = v.a; wd[k] = v.d;
   endtask

   task automatic expect_resp(input int k, input vec_t v);
      exp_t e;
      e.k = k; e.data = v.ed; e.err = v.ee; e.cd = v.rd | v.ee;
      q.push_back(e);
   endtask

   // Scoreboard side: every response pulse pops one expectation.
   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         if (resp[k] === 1'b1) begin
            if (q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_resp: inst %0d responded, none expected", k);
            end else begin
               e = q.pop_front();
               chk("resp_inst", k, e.k);
               if (e.cd) chk("read_data", rdat[k], e.data);
               chk("mem_error", {31'b0, err[k]}, {31'b0, e.err});
            end
         end
      end
   end

   task automatic do_req(input int k, input vec_t v, input string nm);
      int n;
      expect_resp(k, v);
      @(negedge clk);
      drive(k, v);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (resp[k] !== 1'b1 && n < 40);
      chk({nm, "_latency"}, n, lat[k]);
      idle(k);
   endtask

   initial begin
      vec_t v;
      logic [6:0] pat7;
      logic [4:0] pat5;
      //          rd    wr    opt     addr         wdata          exp data       err
      tv[0]  = '{1'b0, 1'b1, 3'b010, 32'h100,  32'hDEADBEEF, 32'h0,        1'b0};
      tv[1]  = '{1'b1, 1'b0, 3'b010, 32'h100,  32'h0,        32'hDEADBEEF, 1'b0};
      tv[2]  = '{1'b0, 1'b1, 3'b000, 32'h101,  32'h00000080, 32'h0,        1'b0};
      tv[3]  = '{1'b1, 1'b0, 3'b000, 32'h101,  32'h0,        32'hFFFFFF80, 1'b0};
      tv[4]  = '{1'b1, 1'b0, 3'b100, 32'h101,  32'h0,        32'h00000080, 1'b0};
      tv[5]  = '{1'b1, 1'b0, 3'b010, 32'h100,  32'h0,        32'hDEAD80EF, 1'b0};
      tv[6]  = '{1'b0, 1'b1, 3'b001, 32'h102,  32'h00008001, 32'h0,        1'b0};
      tv[7]  = '{1'b1, 1'b0, 3'b001, 32'h102,  32'h0,        32'hFFFF8001, 1'b0};
      tv[8]  = '{1'b1, 1'b0, 3'b101, 32'h102,  32'h0,        32'h00008001, 1'b0};
      tv[9]  = '{1'b1, 1'b0, 3'b001, 32'h103,  32'h0,        32'h0,        1'b1};
      tv[10] = '{1'b1, 1'b0, 3'b010, 32'h100,  32'h0,        32'h800180EF, 1'b0};
      tv[11] = '{1'b1, 1'b1, 3'b010, 32'h100,  32'h11111111, 32'h0,        1'b1};
      tv[12] = '{1'b1, 1'b0, 3'b010, 32'h100,  32'h0,        32'h800180EF, 1'b0};
      tv[13] = '{1'b1, 1'b0, 3'b011, 32'h100,  32'h0,        32'h0,        1'b1};
      tv[14] = '{0, 1, 3'b100, 32'h100,  32'hFFFFFFFF, 32'h0,        1'b1};
      tv[15] = '{1'b1, 1'b0, 3'b010, 32'h100,  32'h0,        32'h800180EF, 1'b0};
      tv[16] = '{1'b1, 1'b0, 3'b010, 32'h102,  32'h0,        32'h0,        1'b1};
      tv[17] = '{1'b0, 1'b1, 3'b010, 32'h101,  32'h22222222, 32'h0,        1'b1};
      tv[18] = '{1'b0, 1'b1, 3'b001, 32'h101,  32'h00003333, 32'h0,        1'b1};
      tv[19] = '{1'b1, 1'b0, 3'b010, 32'h100,  32'h0,        32'h800180EF, 1'b0};
      tv[20] = '{1'b0, 1'b1, 3'b010, 32'h1100, 32'h5A5A5A5A, 32'h0,        1'b0};
      tv[21] = '{1'b1, 1'b0, 3'b010, 32'h100,  32'h0,        32'h5A5A5A5A, 1'b0};
      tv[22] = '{1'b0, 1'b1, 3'b000, 32'h103,  32'hFFFFFFC3, 32'h0,        1'b0};
      tv[23] = '{1'b1, 1'b0, 3'b010, 32'h100,  32'h0,        32'hC35A5A5A, 1'b0};
      tv[24] = '{1'b1, 1'b0, 3'b000, 32'h103,  32'h0,        32'hFFFFFFC3, 1'b0};
      tv[25] = '{1'b1, 1'b0, 3'b101, 32'h100,  32'h0,        32'h00005A5A, 1'b0};
      tv[26] = '{1'b1, 1'b0, 3'b111, 32'h100,  32'h0,        32'h0,        1'b1};
      tv[27] = '{1'b1, 1'b0, 3'b110, 32'h100,  32'h0,        32'h0,        1'b1};

      for (int k = 0; k < 3; k++) begin
         rstn[k] = 1'b0;
         idle(k);
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("reset_read_data", rdat[k], 32'h0);
         chk("reset_resp", {31'b0, resp[k]}, 32'h0);
         chk("reset_err", {31'b0, err[k]}, 32'h0);
      end
      for (int k = 0; k < 3; k++) rstn[k] = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 28; i++) do_req(0, tv[i], $sformatf("vec%0d", i));

      // A held request restarts on the cycle after each response.
      v = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hC35A5A5A, 1'b0};
      repeat (4) expect_resp(0, v);
      @(negedge clk);
      drive(0, v);
      pat7 = '0;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         pat7 = {pat7[5:0], resp[0]};
         if (i == 7) idle(0);
      end
      chk("b2b_pattern", {25'b0, pat7}, 32'h55);

      // LATENCY=4: response window and input changes ignored while busy.
      do_req(1, '{1'b0, 1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0}, "l4_sw");
      v = '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0};
      expect_resp(1, v);
      @(negedge clk);
      drive(1, v);
      pat5 = '0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         pat5 = {pat5[3:0], resp[1]};
         if (i == 1) drive(1, '{1'b0, 1'b1, 3'b010, 32'h10, 32'hBAD0BAD0, 32'h0, 1'b0});
         if (i == 4) idle(1);
      end
      chk("l4_resp_window", {27'b0, pat5}, 32'h02);
      do_req(1, '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0}, "l4_lw");

      // LATENCY=3: reset mid-write aborts the transaction and discards the store.
      do_req(2, '{1'b0, 1'b1, 3'b010, 32'h200, 32'h0BADF00D, 32'h0, 1'b0}, "l3_sw");
      do_req(2, '{1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0BADF00D, 1'b0}, "l3_lw");
      @(negedge clk);
      drive(2, '{1'b0, 1'b1, 3'b010, 32'h200, 32'h12345678, 32'h0, 1'b0});
      @(posedge clk);
      @(posedge clk);
      rstn[2] = 1'b0;
      idle(2);
      @(negedge clk);
      chk("abort_read_data", rdat[2], 32'h0);
      chk("abort_err", {31'b0, err[2]}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk("abort_resp", {31'b0, resp[2]}, 32'h0);
         @(negedge clk);
      end
      rstn[2] = 1'b1;
      do_req(2, '{1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0BADF00D, 1'b0}, "l3_after_abort");

      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side end of the core's load/store bus: a word-organised RAM responder that accepts one read or write request at a time from the core, applies the funct3 access size carried on `option`, and returns a single-cycle `mem_response` after a fixed, parameterised latency. It sits between the multicycle core and on-chip storage, serving both instruction fetches and data accesses.

## Interface
- `ADDR_WIDTH`, 10: word-address bits. Storage holds 2**ADDR_WIDTH 32-bit words.
- `LATENCY`, 1: number of cycles from the request capture edge to the `mem_response` edge. Legal values are 1 to 15.
- `clk` input 1: single clock. All state changes on its rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `mem_read` input 1: read request level.
- `mem_write` input 1: write request level.
- `option` input 3: funct3 access type. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `address` input 32: byte address.
- `write_data` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `read_data` output 32: load result, extended to 32 bits.
- `mem_response` output 1: one-cycle completion pulse.
- `mem_error` output 1: error flag, valid only while `mem_response` is high.

## Operation
- FSM states:
  - IDLE: waits for `mem_read | mem_write`. On that edge it captures `address`, `option`, `write_data` and the request type. Goes to BUSY if LATENCY>1, otherwise straight to RESP.
  - BUSY: down-counter initialised to LATENCY-1. Moves to RESP when the counter reaches 1.
  - RESP: `mem_response` high for one cycle, then always returns to IDLE.
- Index is `addr_q[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so out-of-range addresses alias.
- Read extraction:
  - Byte lane is selected by `addr_q[1:0]`; half lane by `addr_q[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Write merge:
  - SB writes only the lane selected by `addr_q[1:0]`.
  - SH writes the half selected by `addr_q[1]`.
  - SW writes all 4 bytes. Unwritten bytes are preserved.
- Error conditions (set `mem_error`=1, `read_data`=0, no storage write):
  - `mem_read` and `mem_write` both high at capture.
  - Illegal option: 011, 110 or 111 on a read; any value other than 000, 001 or 010 on a write.
  - Misaligned access: LH/LHU/SH with `addr_q[0]`=1, or LW/SW with `addr_q[1:0]`≠0.
- Storage is written only on the edge that enters RESP, never earlier.
- Request inputs are ignored outside IDLE. The initiator holds them stable until it sees `mem_response`.

## Timing
- Reset: state=IDLE, counter=0, `mem_response`=0, `mem_error`=0, `read_data`=0. Storage contents are not cleared.
- A request captured at edge E0 gives `mem_response`=1 from edge E0+LATENCY-1 until the next edge.
  - With LATENCY=1, the response is high in the cycle right after capture: the capture edge itself enters RESP.
- `read_data` and `mem_error` are registered. They are valid exactly while `mem_response` is high, then hold their value until the next response.
- Back-to-back requests: the RESP→IDLE edge comes first, and the next capture is on the following edge.
  - A request still asserted in the cycle after `mem_response` is treated as a new request.
  - Minimum spacing between responses is LATENCY+1 cycles.
- Reset asserted mid-transaction aborts immediately. A pending write is discarded and `mem_response` is not issued.
- Read-after-write to the same word returns the new data, since the write completes before any later capture.

## Structure
- Shared package `mem_bus_pkg`:
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - FSM state encoding IDLE/BUSY/RESP (2 bits).
  - The core reuses these funct3 constants for `option`.
- Sub-module `mem_byte_lane` (combinational). Inputs: `option`, `addr[1:0]`, stored word, `write_data`. Outputs:
  - 4-bit byte-enable,
  - merged write word,
  - extended read word,
  - misalign/illegal flag.
- Top-level holds the FSM, latency counter, captured request registers, storage array and output registers.

## Test plan
- SW 0xDEADBEEF to 0x100, then LW 0x100 (LATENCY=1) → response 1 cycle after each capture, `read_data`=0xDEADBEEF, `mem_error`=0.
- SB 0x80 to 0x101 over that word, then LB 0x101 → 0xFFFFFF80; LBU 0x101 → 0x00000080; LW 0x100 → 0xDEAD80EF.
- SH 0x8001 to 0x102, then LH 0x102 → 0xFFFF8001; LHU → 0x00008001. LH 0x103 → `mem_error`=1, `read_data`=0, storage unchanged.
- LATENCY=4: LW captured at edge 10 → `mem_response` high only between edges 13 and 14. Inputs changed at edge 11 are ignored.
- `mem_read` and `mem_write` both high, and separately option=011 on a read → `mem_error`=1 pulse, no write (a follow-up LW returns the old value).
- SW 0x12345678 to 0x200 (LATENCY=3), `resetn` low at edge 1 after capture → no response, LW 0x200 after reset returns the prior contents; outputs are 0 during reset.
